// File: rtl/coin_acceptor.sv
// Coin sensor front end: per-line 2-flop synchronizer and debounce counter,
// single-coin arbitration FSM with post-decision lockout, accepted-coin counter.
//
// state  | meaning
// IDLE   | waiting for a qualify event
// ACCEPT | one coin accepted: pulse its output, bump the coin count
// REJECT | simultaneous coins or disabled: pulse reject_o
// LOCK   | lockout window after a decision, qualify events dropped
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nick_raw,
    input  logic       dime_raw,
    input  logic       quar_raw,
    input  logic       enable_i,
    output logic       nick_o,
    output logic       dime_o,
    output logic       quar_o,
    output logic       reject_o,
    output logic       busy_o,
    output logic [7:0] coin_cnt_o
);
    localparam logic [7:0] DEB_MAX   = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] DEB_FIRE  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] LOCK_LOAD = (LOCKOUT_CYCLES > 0) ? 8'(LOCKOUT_CYCLES - 1) : 8'd0;
    localparam bit         HAS_LOCK  = (LOCKOUT_CYCLES > 0);

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_REJECT, S_LOCK} state_t;

    state_t     state_q, state_d;
    logic [2:0] raw;
    logic [2:0] sync1_q, sync2_q;
    logic [1:0] primed_q;
    logic [2:0] armed_q, armed_d;
    logic [7:0] deb_q [3];
    logic [7:0] deb_d [3];
    logic [2:0] qual;
    logic [2:0] coin_q, coin_d;
    logic [7:0] lock_q, lock_d;
    logic [7:0] cnt_q, cnt_d;

    assign raw = {quar_raw, dime_raw, nick_raw};

    // A line found high coming out of reset must be seen low once (after the
    // synchronizer has refilled) before it may qualify.
    assign armed_d = armed_q | ({3{primed_q[1]}} & ~sync2_q);

    always_comb begin
        qual = 3'b000;
        for (int i = 0; i < 3; i++) begin
            deb_d[i] = 8'd0;
            if (sync2_q[i]) begin
                deb_d[i] = (deb_q[i] == DEB_MAX) ? DEB_MAX : deb_q[i] + 8'd1;
            end
            qual[i] = armed_q[i] && sync2_q[i] && (deb_q[i] == DEB_FIRE);
        end
    end

    always_comb begin
        state_d = state_q;
        coin_d  = coin_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (qual != 3'b000) begin
                    if (enable_i && $onehot(qual)) begin
                        state_d = S_ACCEPT;
                        coin_d  = qual;
                    end else begin
                        state_d = S_REJECT;
                    end
                    lock_d = LOCK_LOAD;
                end
            end
            S_ACCEPT: begin
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                state_d = HAS_LOCK ? S_LOCK : S_IDLE;
            end
            S_REJECT: state_d = HAS_LOCK ? S_LOCK : S_IDLE;
            S_LOCK: begin
                if (lock_q == 8'd0) state_d = S_IDLE;
                else                lock_d  = lock_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q  <= 3'b000;
            sync2_q  <= 3'b000;
            primed_q <= 2'b00;
            armed_q  <= 3'b000;
            for (int i = 0; i < 3; i++) deb_q[i] <= 8'd0;
            state_q  <= S_IDLE;
            coin_q   <= 3'b000;
            lock_q   <= 8'd0;
            cnt_q    <= 8'd0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            primed_q <= {primed_q[0], 1'b1};
            armed_q  <= armed_d;
            for (int i = 0; i < 3; i++) deb_q[i] <= deb_d[i];
            state_q  <= state_d;
            coin_q   <= coin_d;
            lock_q   <= lock_d;
            cnt_q    <= cnt_d;
        end
    end

    assign nick_o     = (state_q == S_ACCEPT) && coin_q[0];
    assign dime_o     = (state_q == S_ACCEPT) && coin_q[1];
    assign quar_o     = (state_q == S_ACCEPT) && coin_q[2];
    assign reject_o   = (state_q == S_REJECT);
    assign busy_o     = (state_q != S_IDLE);
    assign coin_cnt_o = cnt_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed vector table, hand-written lockout/reset
// sequences, and a randomized run checked against a sample-history model.
module tb_coin_acceptor;
    localparam int D    = 4;
    localparam int L    = 8;
    localparam int MAXE = 16384;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       nick_raw = 1'b0, dime_raw = 1'b0, quar_raw = 1'b0;
    logic       enable_i = 1'b1;
    logic       nick_o, dime_o, quar_o, reject_o, busy_o;
    logic [7:0] coin_cnt_o;

    always #5 clk = ~clk;

    coin_acceptor #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
        .clk(clk), .rst(rst),
        .nick_raw(nick_raw), .dime_raw(dime_raw), .quar_raw(quar_raw),
        .enable_i(enable_i),
        .nick_o(nick_o), .dime_o(dime_o), .quar_o(quar_o), .reject_o(reject_o),
        .busy_o(busy_o), .coin_cnt_o(coin_cnt_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: raw samples per edge, decisions derived from the rules.
    int         e = 0;
    logic [2:0] samp [MAXE];
    int         last_rst = 0;
    int         busy_end = -10;
    int         inc_at = -1;
    int         m_cnt = 0;
    logic [3:0] m_pulse;
    logic       m_busy;

    // Per-sequence observations.
    logic [3:0] obs_mask;
    int         obs_np, obs_first, obs_busy, obs_i;
    int         obs_cnt [4];

    typedef struct {
        logic [2:0] raw;
        int         hold;
        int         en_from;
        logic [3:0] exp_mask;
        int         exp_edge;
        int         exp_cnt;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // A line qualifies at edge k when its samples k-D-1..k-2 are all high and
    // sample k-D-2 (taken after the last reset) is low.
    function automatic logic qualifies(input int line, input int k);
        if (k - D - 2 <= last_rst) return 1'b0;
        if (samp[k-D-2][line]) return 1'b0;
        for (int j = k - D - 1; j <= k - 2; j++)
            if (!samp[j][line]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input logic [2:0] raw, input logic en, input logic rstv);
        logic [2:0] q;
        samp[e] = raw;
        m_pulse = 4'b0000;
        if (!rstv) begin
            last_rst = e;
            busy_end = e - 1;
            inc_at   = -1;
            m_cnt    = 0;
        end else begin
            if (inc_at == e && m_cnt < 255) m_cnt++;
            if (e >= busy_end + 2) begin
                q = {qualifies(2, e), qualifies(1, e), qualifies(0, e)};
                if (q != 3'b000) begin
                    if (en && $countones(q) == 1) begin
                        m_pulse = {1'b0, q};
                        inc_at  = e + 1;
                    end else begin
                        m_pulse = 4'b1000;
                    end
                    busy_end = e + L;
                end
            end
        end
        m_busy = (e <= busy_end);
    endtask

    task automatic clr_obs();
        obs_mask  = 4'b0000;
        obs_np    = 0;
        obs_first = -1;
        obs_busy  = 0;
        obs_i     = 0;
        for (int i = 0; i < 4; i++) obs_cnt[i] = 0;
    endtask

    task automatic step(input logic [2:0] raw, input logic en, input logic rstv);
        logic [3:0]  p;
        logic [12:0] act, exp;
        {quar_raw, dime_raw, nick_raw} = raw;
        enable_i = en;
        rst      = rstv;
        @(posedge clk);
        model_edge(raw, en, rstv);
        #1;
        p   = {reject_o, quar_o, dime_o, nick_o};
        act = {p, busy_o, coin_cnt_o};
        exp = {m_pulse, m_busy, 8'(m_cnt)};
        chk($sformatf("model_edge%0d", e), int'(act), int'(exp));
        if (p != 4'b0000) begin
            obs_mask |= p;
            obs_np   += $countones(p);
            if (obs_first < 0) obs_first = obs_i;
            for (int i = 0; i < 4; i++) if (p[i]) obs_cnt[i]++;
        end
        if (busy_o) obs_busy++;
        obs_i++;
        e++;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 1'b1, 1'b1);
    endtask

    task automatic apply_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        clr_obs();
        for (int i = 0; i < 30; i++)
            step((i < v.hold) ? v.raw : 3'b000, (i >= v.en_from), 1'b1);
        chk($sformatf("v%0d_mask", idx), int'(obs_mask), int'(v.exp_mask));
        chk($sformatf("v%0d_edge", idx), obs_first, v.exp_edge);
        chk($sformatf("v%0d_npulse", idx), obs_np, (v.exp_mask != 0) ? 1 : 0);
        chk($sformatf("v%0d_busy", idx), obs_busy, (v.exp_mask != 0) ? L + 1 : 0);
        chk($sformatf("v%0d_cnt", idx), int'(coin_cnt_o), v.exp_cnt);
    endtask

    // Dime accepted at edge 5; quarter raised at qstart and held 6 cycles.
    task automatic lock_edge(input int qstart, input int exp_q);
        clr_obs();
        for (int i = 0; i < 40; i++)
            step({(i >= qstart && i < qstart + 6), (i < 5), 1'b0}, 1'b1, 1'b1);
        chk($sformatf("lockedge%0d_dime", qstart), obs_cnt[1], 1);
        chk($sformatf("lockedge%0d_quar", qstart), obs_cnt[2], exp_q);
    endtask

    int         rem [3];
    logic [2:0] lv;
    logic       en_r;

    initial begin
        //          raw     hold en_from mask     edge cnt
        vecs[0]  = '{3'b001, 10, 0,  4'b0001,  5, 1};
        vecs[1]  = '{3'b010, 10, 0,  4'b0010,  5, 2};
        vecs[2]  = '{3'b100, 10, 0,  4'b0100,  5, 3};
        vecs[3]  = '{3'b010,  3, 0,  4'b0000, -1, 3};
        vecs[4]  = '{3'b101,  6, 0,  4'b1000,  5, 3};
        vecs[5]  = '{3'b100,  6, 99, 4'b1000,  5, 3};
        vecs[6]  = '{3'b100,  6, 0,  4'b0100,  5, 4};
        vecs[7]  = '{3'b111,  6, 0,  4'b1000,  5, 4};
        vecs[8]  = '{3'b001,  4, 0,  4'b0001,  5, 5};
        vecs[9]  = '{3'b010,  6, 5,  4'b0010,  5, 6};
        vecs[10] = '{3'b010,  6, 6,  4'b1000,  5, 6};
        vecs[11] = '{3'b001,  1, 0,  4'b0000, -1, 6};

        // Reset with all lines high: nothing may fire until they drop.
        clr_obs();
        step(3'b111, 1'b1, 1'b0);
        step(3'b111, 1'b1, 1'b0);
        chk("rst_outputs", int'({nick_o, dime_o, quar_o, reject_o, busy_o}), 0);
        chk("rst_cnt", int'(coin_cnt_o), 0);
        for (int i = 0; i < 20; i++) step(3'b111, 1'b1, 1'b1);
        chk("rst_held_nopulse", obs_np, 0);
        idle_steps(10);

        for (int i = 0; i < 12; i++) apply_vec(i);

        // Leaving LOCK: qualify at edge 14 is dropped, at edge 15 accepted.
        lock_edge(9, 0);
        lock_edge(10, 1);

        // Quarter held through the lockout never re-fires; a fresh one does.
        clr_obs();
        for (int i = 0; i < 45; i++) step({(i >= 7 && i < 37), (i < 6), 1'b0}, 1'b1, 1'b1);
        chk("lock_dime", obs_cnt[1], 1);
        chk("lock_noquar", obs_cnt[2], 0);
        chk("lock_busy", obs_busy, L + 1);
        clr_obs();
        for (int i = 0; i < 25; i++) step({(i < 6), 2'b00}, 1'b1, 1'b1);
        chk("lock_requar", obs_cnt[2], 1);

        // Reset during LOCK.
        clr_obs();
        for (int i = 0; i < 8; i++) step({2'b00, (i < 5)}, 1'b1, 1'b1);
        step(3'b000, 1'b1, 1'b0);
        chk("midlock_busy", int'(busy_o), 0);
        chk("midlock_cnt", int'(coin_cnt_o), 0);
        clr_obs();
        idle_steps(20);
        chk("midlock_nopulse", obs_np, 0);

        // Saturation.
        for (int n = 0; n < 257; n++)
            for (int i = 0; i < 16; i++) step({2'b00, (i < 5)}, 1'b1, 1'b1);
        chk("sat_cnt", int'(coin_cnt_o), 255);

        // Randomized run against the model.
        step(3'b000, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0);
        en_r = 1'b1;
        lv   = 3'b000;
        for (int l = 0; l < 3; l++) rem[l] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int l = 0; l < 3; l++) begin
                if (rem[l] == 0) begin
                    lv[l]  = 1'($urandom_range(0, 1));
                    rem[l] = int'($urandom_range(1, 12));
                end
                rem[l]--;
            end
            if ($urandom_range(0, 39) == 0) en_r = ~en_r;
            step(lv, en_r, ($urandom_range(0, 499) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage that sits directly upstream of the vending machine controller. It synchronizes and debounces the three raw coin-sensor lines and arbitrates between them. For each valid coin it emits exactly one single-cycle pulse on the matching output, and these outputs drive the controller's nickel, dime and quarter inputs directly. Simultaneous coins and coins arriving while disabled are diverted to the return chute, and a lockout window after every decision suppresses chute bounce.

## Interface
- DEBOUNCE_CYCLES, default 4: consecutive synchronized-high cycles required to qualify a coin; legal range 1..255.
- LOCKOUT_CYCLES, default 8: cycles of lockout after each accept/reject decision; legal range 0..255 (0 = no lockout).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- nick_raw  in  1  nickel sensor, asynchronous to clk.
- dime_raw  in  1  dime sensor, asynchronous to clk.
- quar_raw  in  1  quarter sensor, asynchronous to clk.
- enable_i  in  1  1 = coins accepted; 0 = every qualified coin is rejected.
- nick_o  out  1  one-cycle pulse per accepted nickel.
- dime_o  out  1  one-cycle pulse per accepted dime.
- quar_o  out  1  one-cycle pulse per accepted quarter.
- reject_o  out  1  one-cycle pulse per rejected coin event.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- coin_cnt_o  out  8  total accepted coins since reset; saturates at 255.

## Operation
- **Synchronizer:** each raw line passes through its own 2-flop synchronizer (sync1 → sync2).
- **Debounce counters:** one per line, width 8.
  - Increments on every edge where sync2 is 1, and saturates at DEBOUNCE_CYCLES.
  - Clears to 0 on any edge where sync2 is 0.
- **Qualify event:** the edge on which a counter steps from DEBOUNCE_CYCLES-1 to DEBOUNCE_CYCLES.
  - A line held high fires exactly once.
  - Re-firing requires the line to go low for at least one sync2 cycle, then high again for DEBOUNCE_CYCLES cycles.
- **FSM states:** IDLE, ACCEPT, REJECT, LOCK.
  - IDLE, exactly one qualify event, enable_i = 1: go to ACCEPT and latch the coin type.
  - IDLE, two or three qualify events on the same edge: go to REJECT.
  - IDLE, any qualify event with enable_i = 0: go to REJECT.
  - ACCEPT (1 cycle): pulse the latched coin output and increment coin_cnt_o (saturating). Next state is LOCK, or IDLE if LOCKOUT_CYCLES = 0.
  - REJECT (1 cycle): pulse reject_o. Next state is LOCK, or IDLE if LOCKOUT_CYCLES = 0.
  - LOCK: hold for exactly LOCKOUT_CYCLES cycles, then go to IDLE.
- **Discarded events:** qualify events occurring while not in IDLE are dropped permanently, with no queuing. Debounce counters keep running during these states, so a line still held high does not re-fire later.
- **Mutual exclusion:** at most one of nick_o, dime_o, quar_o, reject_o is high in any cycle.
- **Output decode:** all outputs are registered or decoded directly from state registers, with no combinational path from any input.

## Timing
- **Reset:** while rst = 0 at an edge:
  - every output is 0;
  - coin_cnt_o = 0, synchronizers = 0, counters = 0, lockout counter = 0;
  - state = IDLE.
- **Reset mid-operation:** any state returns to IDLE on the reset edge, and no pending pulse is emitted afterwards.
- **Edge numbering:** let edge 0 be the first edge that samples raw = 1, with the line then held.
  - sync2 = 1 after edge 1.
  - The counter reaches D (= DEBOUNCE_CYCLES) at edge D+1.
  - The FSM enters ACCEPT/REJECT at edge D+1.
  - The output pulse is high from edge D+1 to edge D+2, so latency is D+1 clocks.
- **Busy window:** busy_o is high from edge D+1 through edge D+2+LOCKOUT_CYCLES, i.e. 1+LOCKOUT_CYCLES cycles.
- **Short glitch:** a raw pulse shorter than D sampled cycles produces no output and no count change.
- **Leaving LOCK:** a qualify event on the same edge the FSM returns to IDLE is dropped. Only events at edges where the state is already IDLE are considered.
- **enable_i timing:** enable_i is sampled only on the qualify edge; changes at any other time have no effect.

## Test plan
Defaults for every scenario: D = 4, L = 8.
- **Reset:** rst = 0 for 2 cycles with all raw lines high → all outputs 0, coin_cnt_o = 0; no pulse until each line has dropped and requalified.
- **Single nickel:** nick_raw held high 10 cycles from edge 0 → nick_o high exactly edge 5–6; busy_o high edges 5–14; coin_cnt_o = 1. Repeat with dime_raw and quar_raw → the matching output pulses and the count reaches 3.
- **Glitch and simultaneous coins:**
  - dime_raw high 3 cycles → no pulse, count unchanged.
  - nick_raw and quar_raw raised on the same cycle, held 6 → reject_o single pulse at edge 5–6, no coin pulse, count unchanged.
- **Disabled:** enable_i = 0, quar_raw held 6 → reject_o pulse only. Then enable_i = 1 and quar_raw pulsed again → quar_o pulse.
- **Lockout:** dime accepted; quar_raw raised 2 cycles after dime_o and held 30 cycles → no quar_o ever, busy_o drops after 8 LOCK cycles. After quar_raw is released and raised again → quar_o fires.
- **Saturation and reset mid-LOCK:**
  - 257 accepted nickels → coin_cnt_o = 255.
  - rst = 0 during LOCK → next cycle busy_o = 0, coin_cnt_o = 0, no pulse.
